// File: rtl/serial_loader_pkg.sv
// serial_loader_pkg: shared definitions for the serial loader slice.
// Holds the parser and receiver state encodings, the ASCII framing
// characters, and the combinational hex/echo helpers.
package serial_loader_pkg;

    // Frame parser states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_HASH    = 3'd2,
        ST_DATA_HI = 3'd3,
        ST_DATA_LO = 3'd4,
        ST_SEP     = 3'd5,
        ST_ERR     = 3'd6
    } state_t;

    // UART receiver states
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_HASH   = 8'h23;
    localparam logic [7:0] CH_SPACE  = 8'h20;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_LF     = 8'h0A;

    typedef struct packed {
        logic       vld;
        logic [3:0] val;
    } hex_t;

    // ASCII hex digit to nibble; vld=0 for any non-hex character
    function automatic hex_t hex_decode(input logic [7:0] c);
        hex_t h;
        h.vld = 1'b0;
        h.val = 4'h0;
        if (c >= 8'h30 && c <= 8'h39) begin
            h.vld = 1'b1;
            h.val = 4'(c - 8'h30);
        end else if (c >= 8'h41 && c <= 8'h46) begin
            h.vld = 1'b1;
            h.val = 4'(c - 8'h37);
        end else if (c >= 8'h61 && c <= 8'h66) begin
            h.vld = 1'b1;
            h.val = 4'(c - 8'h57);
        end
        return h;
    endfunction

    // Lower-case hex letters 'a'-'f' become 'A'-'F'; everything else passes
    function automatic logic [7:0] hex_upcase(input logic [7:0] c);
        if (c >= 8'h61 && c <= 8'h66)
            return c - 8'h20;
        return c;
    endfunction

endpackage

// File: rtl/serial_rx.sv
// serial_rx: 8N1 UART receiver. Two-flop synchronizer, falling-edge start
// detection, mid-bit sampling, stop-bit check. Delivers one-cycle rx_stb
// with rx_byte on a good stop bit, or rx_ferr when the stop bit is low.
module serial_rx
    import serial_loader_pkg::*;
#(
    parameter int CLK_HZ = 24000000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       RESET_n,
    input  logic       RXpin,
    output logic [7:0] rx_byte,
    output logic       rx_stb,
    output logic       rx_ferr
);

    localparam int BIT_CLKS  = CLK_HZ / BAUD;
    localparam int HALF_CLKS = BIT_CLKS / 2;
    localparam int CNT_W     = $clog2(BIT_CLKS + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CLKS - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CLKS - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic             line_prev;
    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    // Synchronize the asynchronous line; idle-high preset avoids a false start
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            sync_p0   <= 1'b1;
            sync_p1   <= 1'b1;
            line_prev <= 1'b1;
        end else begin
            sync_p0   <= RXpin;
            sync_p1   <= sync_p0;
            line_prev <= sync_p1;
        end
    end

    // Bit timing and deframing; returns to idle right after the stop sample
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            state   <= RX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            rx_byte <= '0;
            rx_stb  <= 1'b0;
            rx_ferr <= 1'b0;
        end else begin
            rx_stb  <= 1'b0;
            rx_ferr <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (line_prev && !sync_p1) begin
                        state <= RX_START;
                        cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        // A glitch that is high again at mid-bit is dropped silently
                        state   <= sync_p1 ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shreg <= {sync_p1, shreg[7:1]};
                        if (bit_idx == 3'd7)
                            state <= RX_STOP;
                        else
                            bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (sync_p1) begin
                            rx_stb  <= 1'b1;
                            rx_byte <= shreg;
                        end else begin
                            rx_ferr <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/serial_loader.sv
// serial_loader: receives "$AAAA#hh hh ... hh<CR>" frames over UART and
// turns each hex byte into a RAM write at an auto-incrementing address.
// Optional build macro SERIAL_LOADER_ECHO_EN adds echo_byte/echo_stb, a
// one-cycle-delayed copy of every received byte with hex letters upper-cased.
module serial_loader
    import serial_loader_pkg::*;
#(
    parameter int CLK_HZ = 24000000,
    parameter int BAUD   = 115200,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              RESET_n,
    input  logic              RXpin,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_done,
    output logic              err,
    output logic              busy
`ifdef SERIAL_LOADER_ECHO_EN
    ,
    output logic [7:0]        echo_byte,
    output logic              echo_stb
`endif
);

    logic [7:0]        rx_byte;
    logic              rx_stb;
    logic              rx_ferr;
    hex_t              hx;
    state_t            state;
    logic [ADDR_W-1:0] addr_sr;
    logic [1:0]        dig_cnt;
    logic [3:0]        hi_nib;

    serial_rx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_rx (
        .clk     (clk),
        .RESET_n (RESET_n),
        .RXpin   (RXpin),
        .rx_byte (rx_byte),
        .rx_stb  (rx_stb),
        .rx_ferr (rx_ferr)
    );

    assign hx   = hex_decode(rx_byte);
    assign busy = (state != ST_IDLE);

    // Frame parser, address counter and registered write/status strobes
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            state      <= ST_IDLE;
            addr_sr    <= '0;
            dig_cnt    <= '0;
            hi_nib     <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            // Address advances in the cycle after each write strobe
            if (wr_en)
                wr_addr <= wr_addr + 1'b1;

            if (rx_ferr) begin
                if (state == ST_IDLE) begin
                    err <= 1'b1;
                end else begin
                    state <= ST_ERR;
                    if (state != ST_ERR)
                        err <= 1'b1;
                end
            end else if (rx_stb && rx_byte != CH_LF) begin
                if (rx_byte == CH_DOLLAR) begin
                    // '$' always (re)starts a frame, no error reported
                    state   <= ST_ADDR;
                    addr_sr <= '0;
                    dig_cnt <= '0;
                end else begin
                    case (state)
                        ST_IDLE: begin
                        end
                        ST_ADDR: begin
                            if (hx.vld) begin
                                // Keeping only ADDR_W bits drops the upper digits
                                addr_sr <= ADDR_W'({addr_sr, hx.val});
                                dig_cnt <= dig_cnt + 1'b1;
                                if (dig_cnt == 2'd3)
                                    state <= ST_HASH;
                            end else begin
                                state <= ST_ERR;
                                err   <= 1'b1;
                            end
                        end
                        ST_HASH: begin
                            if (rx_byte == CH_HASH) begin
                                state   <= ST_DATA_HI;
                                wr_addr <= addr_sr;
                            end else begin
                                state <= ST_ERR;
                                err   <= 1'b1;
                            end
                        end
                        ST_DATA_HI: begin
                            if (hx.vld) begin
                                hi_nib <= hx.val;
                                state  <= ST_DATA_LO;
                            end else if (rx_byte == CH_CR) begin
                                state      <= ST_IDLE;
                                frame_done <= 1'b1;
                            end else begin
                                state <= ST_ERR;
                                err   <= 1'b1;
                            end
                        end
                        ST_DATA_LO: begin
                            if (hx.vld) begin
                                wr_en   <= 1'b1;
                                wr_data <= {hi_nib, hx.val};
                                state   <= ST_SEP;
                            end else begin
                                state <= ST_ERR;
                                err   <= 1'b1;
                            end
                        end
                        ST_SEP: begin
                            if (rx_byte == CH_SPACE) begin
                                state <= ST_DATA_HI;
                            end else if (rx_byte == CH_CR) begin
                                state      <= ST_IDLE;
                                frame_done <= 1'b1;
                            end else begin
                                state <= ST_ERR;
                                err   <= 1'b1;
                            end
                        end
                        ST_ERR: begin
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

`ifdef SERIAL_LOADER_ECHO_EN
    // Echo every delivered byte one cycle later, hex letters upper-cased
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            echo_stb  <= 1'b0;
            echo_byte <= '0;
        end else begin
            echo_stb <= rx_stb;
            if (rx_stb)
                echo_byte <= hex_upcase(rx_byte);
        end
    end
`endif

endmodule

// File: tb/tb_serial_loader.sv
// tb_serial_loader: scoreboard bench for serial_loader. Stimulus pushes the
// expected write/done/err events; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_serial_loader;

    localparam int CLK_HZ   = 24000000;
    localparam int BAUD     = 1500000;
    localparam int BIT_CLKS = CLK_HZ / BAUD;
    localparam int ADDR_W   = 10;

    localparam logic [1:0] EV_WR   = 2'd0;
    localparam logic [1:0] EV_DONE = 2'd1;
    localparam logic [1:0] EV_ERR  = 2'd2;

    typedef struct packed {
        logic [1:0]        kind;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } evt_t;

    logic              clk = 1'b0;
    logic              RESET_n;
    logic              RXpin;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              frame_done;
    logic              err;
    logic              busy;
`ifdef SERIAL_LOADER_ECHO_EN
    logic [7:0]        echo_byte;
    logic              echo_stb;
    logic [7:0]        echo_q[$];
`endif

    evt_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    serial_loader #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .RESET_n    (RESET_n),
        .RXpin      (RXpin),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .err        (err),
        .busy       (busy)
`ifdef SERIAL_LOADER_ECHO_EN
        ,
        .echo_byte  (echo_byte),
        .echo_stb   (echo_stb)
`endif
    );

    task automatic check_evt(input logic [1:0] kind, input logic [ADDR_W-1:0] a,
                             input logic [7:0] d);
        evt_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: got kind=%0d addr=%03h data=%02h, required no event",
                     kind, a, d);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || (kind == EV_WR && (e.addr != a || e.data != d))) begin
                n_err++;
                $display("FAIL event: got kind=%0d addr=%03h data=%02h, required kind=%0d addr=%03h data=%02h",
                         kind, a, d, e.kind, e.addr, e.data);
            end
        end
    endtask

    // Monitor: compare every DUT strobe against the head of the scoreboard
    always @(negedge clk) begin
        if (RESET_n === 1'b1) begin
            if (wr_en)      check_evt(EV_WR, wr_addr, wr_data);
            if (frame_done) check_evt(EV_DONE, '0, '0);
            if (err)        check_evt(EV_ERR, '0, '0);
`ifdef SERIAL_LOADER_ECHO_EN
            if (echo_stb) begin
                n_vec++;
                if (echo_q.size() == 0) begin
                    n_err++;
                    $display("FAIL echo_unexpected: got %02h, required none", echo_byte);
                end else begin
                    logic [7:0] ex;
                    ex = echo_q.pop_front();
                    if (echo_byte !== ex) begin
                        n_err++;
                        $display("FAIL echo: got %02h, required %02h", echo_byte, ex);
                    end
                end
            end
`endif
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic exp_wr(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        evt_t e;
        e.kind = EV_WR; e.addr = a; e.data = d;
        sb.push_back(e);
    endtask

    task automatic exp_ev(input logic [1:0] k);
        evt_t e;
        e.kind = k; e.addr = '0; e.data = '0;
        sb.push_back(e);
    endtask

    // One 8N1 character, LSB first; stop_bit=0 forces a framing error
    task automatic send_raw(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            RXpin = bits[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        RXpin = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
`ifdef SERIAL_LOADER_ECHO_EN
        echo_q.push_back((b >= 8'h61 && b <= 8'h66) ? b - 8'h20 : b);
`endif
        send_raw(b, 1'b1);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++)
            send_byte(8'(s[i]));
    endtask

    // Bounded wait for all pushed events to be consumed by the monitor
    task automatic wait_drain(input string name);
        for (int i = 0; i < 200 && sb.size() != 0; i++)
            @(negedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain_%s: got %0d events outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        RESET_n = 1'b0;
        RXpin   = 1'b1;
        repeat (4) @(negedge clk);
        chk("reset_wr_en", {15'd0, wr_en}, 16'd0);
        chk("reset_outputs", {3'd0, wr_addr, frame_done, err, busy},
            16'd0);
        chk("reset_wr_data", {8'd0, wr_data}, 16'd0);
        RESET_n = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);

        // Basic frame, mixed-case hex
        exp_wr(10'h010, 8'hAB); exp_wr(10'h011, 8'hCD); exp_ev(EV_DONE);
        send_str("$0010#AB cd"); send_byte(8'h0D);
        wait_drain("basic");
        chk("busy_after_frame", {15'd0, busy}, 16'd0);

        // Address wrap at the top of RAM
        exp_wr(10'h3FF, 8'h11); exp_wr(10'h000, 8'h22); exp_ev(EV_DONE);
        send_str("$03FF#11 22"); send_byte(8'h0D);
        wait_drain("wrap");

        // Upper address bits discarded
        exp_wr(10'h005, 8'h5A); exp_ev(EV_DONE);
        send_str("$F005#5A"); send_byte(8'h0D);
        wait_drain("upper_bits");

        // Syntax error on 'G', rest of line ignored while in ERR
        exp_ev(EV_ERR);
        send_str("$0020#1G 33"); send_byte(8'h0D);
        wait_drain("syntax_err");
        chk("busy_in_err", {15'd0, busy}, 16'd1);

        // Recovery from ERR on '$'
        exp_wr(10'h020, 8'h33); exp_ev(EV_DONE);
        send_str("$0020#33"); send_byte(8'h0D);
        wait_drain("recover");
        chk("busy_after_recover", {15'd0, busy}, 16'd0);

        // Mid-frame '$' restarts without an error
        exp_wr(10'h040, 8'h01); exp_wr(10'h050, 8'h02); exp_ev(EV_DONE);
        send_str("$0040#01 $0050#02"); send_byte(8'h0D);
        wait_drain("restart");

        // Empty data list with a stray LF
        exp_ev(EV_DONE);
        send_byte(8'h0A); send_str("$0100#"); send_byte(8'h0A); send_byte(8'h0D);
        wait_drain("empty_lf");

        // Framing error while idle: err only, '$' must not be delivered
        exp_ev(EV_ERR);
        send_raw(8'h24, 1'b0);
        wait_drain("ferr");
        chk("busy_after_ferr", {15'd0, busy}, 16'd0);

        // Reset asserted mid-frame aborts without a write
        send_str("$0060#7");
        chk("busy_mid_frame", {15'd0, busy}, 16'd1);
        RESET_n = 1'b0;
        #1;
        chk("midreset_wr_addr", {6'd0, wr_addr}, 16'd0);
        chk("midreset_flags", {12'd0, wr_en, frame_done, err, busy}, 16'd0);
        chk("midreset_wr_data", {8'd0, wr_data}, 16'd0);
        repeat (5) @(negedge clk);
        RESET_n = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        chk("busy_after_reset", {15'd0, busy}, 16'd0);

        // Lower-case address and data after reset
        exp_wr(10'h0A0, 8'hFF); exp_ev(EV_DONE);
        send_str("$00a0#ff"); send_byte(8'h0D);
        wait_drain("lowercase");

        repeat (4 * BIT_CLKS) @(negedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL final_queue: got %0d outstanding, required 0", sb.size());
        end
`ifdef SERIAL_LOADER_ECHO_EN
        n_vec++;
        if (echo_q.size() != 0) begin
            n_err++;
            $display("FAIL echo_queue: got %0d outstanding, required 0", echo_q.size());
        end
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_loader.md
Name: serial_loader

Overview:
- UART-receive counterpart of the serial debug dumper: accepts the same ASCII hex frame format on RXpin and writes the decoded bytes into block RAM.
- Host sends "$AAAA#hh hh ... hh<CR>"; each hex byte becomes one RAM write at an auto-incrementing address.
- Sits beside the dumper on the 24 MHz domain; its write port muxes onto the BRAM AD/DI/WRE pins.

Parameters:
- CLK_HZ, 24000000, system clock frequency.
- BAUD, 115200, line rate. Bit period BIT_CLKS = CLK_HZ/BAUD (208 at defaults), integer-truncated.
- ADDR_W, 10, RAM byte-address width. Upper address-digit bits beyond ADDR_W are discarded.

Ports:
- clk  in  1  system clock; all logic on posedge.
- RESET_n  in  1  asynchronous, active-low reset.
- RXpin  in  1  UART line, idle high, 8N1, LSB first; asynchronous to clk.
- wr_en  out  1  one-cycle write strobe.
- wr_addr  out  ADDR_W  write address, valid when wr_en=1.
- wr_data  out  8  write byte, valid when wr_en=1.
- frame_done  out  1  one-cycle pulse when a CR terminates a well-formed frame.
- err  out  1  one-cycle pulse on a framing or syntax error.
- busy  out  1  high while a frame is being parsed (state other than IDLE).

Behaviour:
- Reset: all outputs 0, parser in IDLE, RX in idle, address register 0, synchronizer flops preset to 1.
- Reset is asynchronous and active-low; asserting it mid-frame aborts the frame, and no write is issued.
- RX front end (sub-module):
  - RXpin passes through a 2-flop synchronizer.
  - A falling edge starts a bit counter, and the line is sampled at BIT_CLKS/2.
  - If the start bit is not low at mid-bit, the receiver returns to idle silently.
  - Eight data bits are sampled at BIT_CLKS intervals.
  - At the stop-bit midpoint: if the line is high, rx_stb pulses for one cycle with rx_byte. If it is low, rx_ferr pulses and no byte is delivered.
  - The receiver rearms immediately after the stop-bit sample.
- Hex decode is combinational: '0'-'9', 'A'-'F' and 'a'-'f' map to 0-15; anything else is non-hex.
- Parser FSM advances only on rx_stb:
  - IDLE: '$' -> ADDR (clear address shift register, digit count=0). Any other byte is ignored.
  - ADDR: hex digit shifts into a 16-bit register; after the 4th digit -> HASH. Non-hex -> ERR.
  - HASH: '#' -> DATA_HI and load wr_addr from shiftreg[ADDR_W-1:0]. Otherwise -> ERR.
  - DATA_HI: hex digit latches the high nibble -> DATA_LO. CR (0x0D) -> IDLE with frame_done; an empty data list is legal. Otherwise -> ERR.
  - DATA_LO: hex digit -> SEP and issues the write (see write timing). Otherwise -> ERR.
  - SEP: ' ' -> DATA_HI. CR -> IDLE with frame_done. Otherwise -> ERR.
  - ERR: err pulses once on entry. Then wait: '$' -> ADDR, any other byte stays in ERR.
  - In every state other than IDLE and ERR, a '$' restarts at ADDR with no err pulse.
  - LF (0x0A) is ignored in every state.
  - rx_ferr in any state other than IDLE -> ERR; in IDLE it only pulses err.
- Write timing:
  - wr_en is high for the cycle immediately after the rx_stb carrying the low nibble.
  - wr_data = {hi, lo}, and wr_addr holds the current address during that cycle.
  - The address increments in the following cycle, wrapping modulo 2^ADDR_W (0x3FF -> 0x000).
- Writes are committed byte-by-byte; a frame aborted later keeps its earlier writes.
- The write port has no backpressure: the RAM must accept a write every cycle. At most one write occurs per received character pair, so writes are at least 20 bit-times apart.
- busy = (state != IDLE), including while in ERR.

Optional Feature:
- SERIAL_LOADER_ECHO_EN defined: adds ports echo_byte (out, 8) and echo_stb (out, 1).
  - Every valid rx_stb byte is presented one cycle later with echo_stb high for one cycle, for the debug serial_tx.
  - The echo is upper-case normalised for hex letters.
- Macro undefined: these ports and their logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package/include holds:
  - parser state encodings: ST_IDLE, ST_ADDR, ST_HASH, ST_DATA_HI, ST_DATA_LO, ST_SEP, ST_ERR (3 bits);
  - ASCII constants CH_DOLLAR 8'h24, CH_HASH 8'h23, CH_SPACE 8'h20, CH_CR 8'h0D, CH_LF 8'h0A.
- One sub-module, serial_rx: sync, bit timing and deframing. Its outputs are rx_byte, rx_stb and rx_ferr.
- The parser and address counter live in serial_loader.

Test Plan:
- Send "$0010#AB cd\r" at 115200 -> writes (0x010,0xAB) then (0x011,0xCD); frame_done pulses once; err never pulses.
- Send "$03FF#11 22\r" -> writes (0x3FF,0x11) then (0x000,0x22), verifying wrap; also send "$F005#5A\r" -> write (0x005,0x5A), verifying upper address bits are dropped.
- Send "$0020#1G 33\r" -> err pulses on 'G' with no writes; then send "$0020#33\r" -> write (0x020,0x33) and frame_done.
- Send "$0040#01 $0050#02\r" -> write (0x040,0x01), restart with no err, write (0x050,0x02), one frame_done.
- Drive a byte with the stop bit held low -> err pulses and no rx byte is delivered; separately, assert RESET_n low mid "$0060#7" -> no write, all outputs 0, busy 0.
- With SERIAL_LOADER_ECHO_EN, send "$00a0#ff\r" -> echo_stb pulses 9 times with "$00A0#FF",0x0D.
